// File: rtl/bus_timer_io_pkg.sv
// bus_timer_io_pkg: shared constants for the bus_timer_io peripheral.
//   - word offsets (addr[4:2]) of the eight registers
//   - CTRL and STATUS bit positions
//   - reset value of COMPARE
package bus_timer_io_pkg;

    localparam logic [2:0] OffCtrl     = 3'd0;
    localparam logic [2:0] OffPrescale = 3'd1;
    localparam logic [2:0] OffCount    = 3'd2;
    localparam logic [2:0] OffCompare  = 3'd3;
    localparam logic [2:0] OffStatus   = 3'd4;
    localparam logic [2:0] OffGpioOut  = 3'd5;
    localparam logic [2:0] OffGpioIn   = 3'd6;
    localparam logic [2:0] OffId       = 3'd7;

    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlAutoBit  = 1;
    localparam int unsigned CtrlIrqEnBit = 2;
    localparam int unsigned CtrlW        = 3;

    localparam int unsigned StatusMatchBit = 0;

    localparam logic [31:0] CompareRst = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_timer_io_synchronizer.sv
// bus_timer_io_synchronizer: two-flop synchronizer for asynchronous input pins.
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears both stages
//   d_i    - asynchronous input
//   q_o    - synchronized output, two edges behind d_i
module bus_timer_io_synchronizer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bus_timer_io.sv
// bus_timer_io: memory-mapped timer/GPIO responder on the CPU data bus, zero wait states.
//   clk            - system clock
//   rst            - asynchronous active-low reset
//   addr           - byte address; addr[4:2] selects the register
//   cs, wr_rd      - chip select, 1 = write / 0 = read
//   data_bus_write - write data, committed on the edge ending the bus cycle
//   data_bus_read  - combinational read data, 0 when not reading
//   gpio_out       - registered output port
//   gpio_in        - asynchronous input pins (synchronized before readback)
//   irq            - level interrupt, MATCH & IRQ_EN
module bus_timer_io
    import bus_timer_io_pkg::*;
#(
    parameter int unsigned GPIO_W   = 8,
    parameter logic [31:0] ID_VALUE = 32'h4D49_5053
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              cs,
    input  logic              wr_rd,
    input  logic [31:0]       data_bus_write,
    output logic [31:0]       data_bus_read,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              irq
);

    logic [CtrlW-1:0]  ctrl_q,     ctrl_d;
    logic [15:0]       prescale_q, prescale_d;
    logic [15:0]       pcnt_q,     pcnt_d;
    logic [31:0]       count_q,    count_d;
    logic [31:0]       compare_q,  compare_d;
    logic              match_q,    match_d;
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] gpio_in_sync;
    logic [31:0]       rdata;

    logic [2:0] reg_sel;
    logic       wr_en;
    logic       tick;
    logic       hit;
    logic       unused_addr;

    assign reg_sel     = addr[4:2];
    assign unused_addr = ^{addr[31:5], addr[1:0]};
    assign wr_en       = cs & wr_rd;
    assign tick        = ctrl_q[CtrlEnBit] & (pcnt_q == prescale_q);
    assign hit         = tick & (count_q == compare_q);

    bus_timer_io_synchronizer #(
        .Width (GPIO_W)
    ) u_gpio_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (gpio_in),
        .q_o    (gpio_in_sync)
    );

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        match_d    = match_q;
        gpio_out_d = gpio_out_q;

        // Prescaler and counter advance first; CPU writes below override them.
        if (!ctrl_q[CtrlEnBit]) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        if (hit && ctrl_q[CtrlAutoBit]) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        if (wr_en) begin
            case (reg_sel)
                OffCtrl:     ctrl_d = data_bus_write[CtrlW-1:0];
                OffPrescale: begin
                    prescale_d = data_bus_write[15:0];
                    pcnt_d     = '0;
                end
                OffCount:    count_d   = data_bus_write;
                OffCompare:  compare_d = data_bus_write;
                OffStatus:   begin
                    if (data_bus_write[StatusMatchBit]) begin
                        match_d = 1'b0;
                    end
                end
                OffGpioOut:  gpio_out_d = data_bus_write[GPIO_W-1:0];
                default:     ; // GPIO_IN and ID are read-only
            endcase
        end

        // A match on the same edge as a W1C clear must survive.
        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            count_q    <= '0;
            compare_q  <= CompareRst;
            match_q    <= 1'b0;
            gpio_out_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            gpio_out_q <= gpio_out_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            OffCtrl:     rdata[CtrlW-1:0]      = ctrl_q;
            OffPrescale: rdata[15:0]           = prescale_q;
            OffCount:    rdata                 = count_q;
            OffCompare:  rdata                 = compare_q;
            OffStatus:   rdata[StatusMatchBit] = match_q;
            OffGpioOut:  rdata[GPIO_W-1:0]     = gpio_out_q;
            OffGpioIn:   rdata[GPIO_W-1:0]     = gpio_in_sync;
            OffId:       rdata                 = ID_VALUE;
            default:     rdata                 = '0;
        endcase
    end

    // Gated by rst so the constant ID cannot leak onto the bus during reset.
    assign data_bus_read = (rst && cs && !wr_rd) ? rdata : 32'h0;
    assign gpio_out      = gpio_out_q;
    assign irq           = match_q & ctrl_q[CtrlIrqEnBit];

endmodule

// File: tb/tb_bus_timer_io.sv
// Scoreboard bench for bus_timer_io: read tasks queue expected values, a negedge monitor
// pops and compares while the stimulus keeps going.
module tb_bus_timer_io;

    localparam logic [31:0] IdVal = 32'h4D49_5053;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        cs;
    logic        wr_rd;
    logic [31:0] data_bus_write;
    logic [31:0] data_bus_read;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in;
    logic        irq;

    bus_timer_io #(
        .GPIO_W   (8),
        .ID_VALUE (IdVal)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .cs             (cs),
        .wr_rd          (wr_rd),
        .data_bus_write (data_bus_write),
        .data_bus_read  (data_bus_read),
        .gpio_out       (gpio_out),
        .gpio_in        (gpio_in),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        bit          chk_irq;
        logic        exp_irq;
        bit          chk_gpio;
        logic [7:0]  exp_gpio;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    logic mon_req;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: one observation per requested read cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_req) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: observation with no expected entry");
            end else begin
                e = sb_q.pop_front();
                n_cmp++;
                if (data_bus_read !== e.data) begin
                    n_bad++;
                    $display("FAIL %s data: got %h want %h", e.name, data_bus_read, e.data);
                end
                if (e.chk_irq) begin
                    n_cmp++;
                    if (irq !== e.exp_irq) begin
                        n_bad++;
                        $display("FAIL %s irq: got %b want %b", e.name, irq, e.exp_irq);
                    end
                end
                if (e.chk_gpio) begin
                    n_cmp++;
                    if (gpio_out !== e.exp_gpio) begin
                        n_bad++;
                        $display("FAIL %s gpio_out: got %h want %h", e.name, gpio_out, e.exp_gpio);
                    end
                end
            end
        end
    end

    // Every task starts just after a rising edge and consumes exactly one edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        cs = 1'b1; wr_rd = 1'b1; addr = a; data_bus_write = d; mon_req = 1'b0;
        cycle();
        cs = 1'b0; wr_rd = 1'b0;
    endtask

    task automatic rd_full(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input bit ci, input logic ei, input bit cg, input logic [7:0] eg,
                           input logic sel);
        exp_t x;
        x.name = nm; x.data = d; x.chk_irq = ci; x.exp_irq = ei;
        x.chk_gpio = cg; x.exp_gpio = eg;
        sb_q.push_back(x);
        cs = sel; wr_rd = 1'b0; addr = a; mon_req = 1'b1;
        cycle();
        cs = 1'b0; mon_req = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] d);
        rd_full(nm, a, d, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic rd_irq(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic ei);
        rd_full(nm, a, d, 1'b1, ei, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cs = 1'b0; wr_rd = 1'b0; addr = '0; data_bus_write = '0;
        gpio_in = 8'h00; mon_req = 1'b0;
        cycle();

        // Reset: ID address selected but bus must read 0.
        rd_full("rst_read", 32'h1C, 32'h0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        rst = 1'b1;
        rd("id", 32'h1C, IdVal);
        rd("id_lowbits_ignored", 32'h1F, IdVal);
        rd("compare_rst", 32'h0C, 32'hFFFF_FFFF);
        rd("ctrl_rst", 32'h00, 32'h0);
        rd("count_rst", 32'h08, 32'h0);
        rd_irq("status_rst", 32'h10, 32'h0, 1'b0);

        // Count and match: PRESCALE=2 -> ticks at N+3, N+6, ...
        bus_wr(32'h04, 32'd2);
        bus_wr(32'h0C, 32'd3);
        bus_wr(32'h00, 32'h5);               // edge N
        rd("ctrl", 32'h00, 32'h5);           // sees after N
        rd("cm_count0", 32'h08, 32'd0);
        rd("prescale", 32'h04, 32'd2);
        rd("cm_count1", 32'h08, 32'd1);      // after N+3
        rd("compare", 32'h0C, 32'd3);
        idle(1);
        rd("cm_count2", 32'h08, 32'd2);      // after N+6
        idle(2);
        rd("cm_count3", 32'h08, 32'd3);      // after N+9
        rd_irq("cm_nomatch_yet", 32'h10, 32'h0, 1'b0);
        idle(1);
        rd_irq("cm_match", 32'h10, 32'h1, 1'b1);  // after N+12
        rd("cm_count4", 32'h08, 32'd4);
        bus_wr(32'h10, 32'h1);               // W1C on a non-matching tick
        rd_irq("cm_cleared", 32'h10, 32'h0, 1'b0);
        bus_wr(32'h00, 32'h0);

        // Collision: COUNT write on a tick edge wins.
        bus_wr(32'h04, 32'd0);
        bus_wr(32'h0C, 32'hFFFF_FF00);
        bus_wr(32'h08, 32'd0);
        bus_wr(32'h00, 32'h1);               // edge M
        bus_wr(32'h08, 32'h100);             // edge M+1, also a tick
        rd("col_write_wins", 32'h08, 32'h100);
        rd("col_then_counts", 32'h08, 32'h101);
        bus_wr(32'h00, 32'h0);

        // Collision: W1C on the matching tick keeps MATCH.
        bus_wr(32'h08, 32'd3);
        bus_wr(32'h0C, 32'd5);
        bus_wr(32'h00, 32'h1);               // edge M
        idle(2);                             // 3->4->5
        bus_wr(32'h10, 32'h1);               // edge M+3, count==compare
        rd_irq("w1c_set_wins", 32'h10, 32'h1, 1'b0);
        rd("w1c_count", 32'h08, 32'd7);
        bus_wr(32'h00, 32'h0);
        bus_wr(32'h10, 32'h1);
        rd("w1c_clear", 32'h10, 32'h0);

        // Auto-reload: 0,1,0,1...
        bus_wr(32'h08, 32'd0);
        bus_wr(32'h0C, 32'd1);
        bus_wr(32'h00, 32'h3);
        rd("ar_0", 32'h08, 32'd0);
        rd("ar_1", 32'h08, 32'd1);
        rd("ar_2", 32'h08, 32'd0);
        rd("ar_3", 32'h08, 32'd1);
        rd_irq("ar_match", 32'h10, 32'h1, 1'b0);
        bus_wr(32'h00, 32'h0);
        bus_wr(32'h10, 32'h1);
        rd("ar_clear", 32'h10, 32'h0);

        // Wrap: FFFFFFFF -> 0 -> 1 without MATCH.
        bus_wr(32'h08, 32'hFFFF_FFFF);
        bus_wr(32'h0C, 32'h10);
        bus_wr(32'h00, 32'h1);
        rd("wrap_max", 32'h08, 32'hFFFF_FFFF);
        rd("wrap_0", 32'h08, 32'd0);
        rd("wrap_1", 32'h08, 32'd1);
        rd("wrap_nomatch", 32'h10, 32'h0);
        bus_wr(32'h00, 32'h0);

        // GPIO
        bus_wr(32'h14, 32'h1A5);
        rd_full("gpio_out", 32'h14, 32'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
        gpio_in = 8'h3C;
        rd("gpio_in_e0", 32'h18, 32'h0);
        rd("gpio_in_e1", 32'h18, 32'h0);
        rd("gpio_in_e2", 32'h18, 32'h3C);
        bus_wr(32'h1C, 32'h0);
        rd("id_ro", 32'h1C, IdVal);
        bus_wr(32'h18, 32'hFF);
        rd("gpio_in_ro", 32'h18, 32'h3C);
        rd_full("cs_low", 32'h1C, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Mid-operation reset with irq high.
        bus_wr(32'h0C, 32'd0);
        bus_wr(32'h08, 32'd0);
        bus_wr(32'h00, 32'h5);               // edge M; hit at M+1
        idle(1);
        rd_irq("pre_reset_irq", 32'h10, 32'h1, 1'b1);
        rst = 1'b0;
        rd_full("mid_reset", 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        rst = 1'b1;
        rd("post_reset_count", 32'h08, 32'h0);
        rd("post_reset_compare", 32'h0C, 32'hFFFF_FFFF);
        rd("post_reset_ctrl", 32'h00, 32'h0);

        for (int i = 0; i < 4 && sb_q.size() != 0; i++) cycle();
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries never observed", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_timer_io.md
# bus_timer_io

Memory-mapped timer/GPIO peripheral that answers the CPU's external data bus: the CPU is the initiator (addr, cs, wr_rd, data_bus_write) and this block is the responder that drives data_bus_read. It sits outside the CPU on the system clock. It has no wait states. Read data is combinational from the bus address, so the CPU's MEM stage can register it into the WB stage on the same rising edge. Writes commit on the rising edge that ends the bus cycle.

## Interface

- GPIO_W, 8, width of gpio_out / gpio_in
- ID_VALUE, 32'h4D495053, constant returned by the ID register
- clk  input  1  system clock (same clock the CPU pipeline uses)
- rst  input  1  reset, asynchronous, active-low (all state cleared while low)
- addr  input  32  byte address from CPU; only addr[4:2] decoded, addr[1:0] ignored
- cs  input  1  chip select; CPU's address decoder selected this peripheral
- wr_rd  input  1  1 = write, 0 = read
- data_bus_write  input  32  write data
- data_bus_read  output  32  read data
- gpio_out  output  GPIO_W  registered output port
- gpio_in  input  GPIO_W  asynchronous input pins
- irq  output  1  interrupt request, level

## Operation

- Register map (word offset = addr[4:2]):
  - 0 CTRL: RW. bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
  - 1 PRESCALE: RW. Bits [15:0].
  - 2 COUNT: RW. A write loads the counter.
  - 3 COMPARE: RW.
  - 4 STATUS: bit0 MATCH, sticky. Writing 1 to bit0 clears it.
  - 5 GPIO_OUT: RW. Low GPIO_W bits.
  - 6 GPIO_IN: RO. Returns the synchronized pins.
  - 7 ID: RO. Returns ID_VALUE.
- Write: on a rising edge with cs=1 and wr_rd=1, the addressed register updates from data_bus_write. Writes to RO offsets are ignored.
- Read: data_bus_read = register[addr[4:2]] when cs=1 and wr_rd=0; otherwise 32'h0. It is purely combinational and shows pre-edge values.
- Prescaler: pcnt is 16-bit.
  - When EN=1 and pcnt==PRESCALE, a tick occurs and pcnt←0; otherwise pcnt increments.
  - When EN=0, pcnt is held at 0.
  - PRESCALE=0 gives a tick every cycle.
- Tick action:
  - If COUNT==COMPARE: MATCH←1, and COUNT←0 if AUTO_RELOAD, else COUNT+1.
  - Otherwise COUNT←COUNT+1, wrapping 32'hFFFFFFFF→0 with no flag.
- Simultaneous events:
  - A CPU write to COUNT and a tick on the same edge: the write wins and the tick is lost.
  - A write to PRESCALE also clears pcnt.
  - A MATCH set and a W1C clear on the same edge: the set wins.
- irq = MATCH & IRQ_EN, driven combinationally from registers.
- gpio_in passes through a two-flop synchronizer before it is visible at offset 6.

## Timing

- Reset values:
  - CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFFFFFF, MATCH=0, GPIO_OUT=0, pcnt=0.
  - Synchronizer flops = 0.
  - data_bus_read=0 and irq=0 while rst=0.
- Reset mid-operation clears everything immediately. There is no partial-write recovery.
- Read latency is 0 cycles (same cycle as cs/addr). Write latency: visible on read and on outputs the cycle after the write edge.
- EN written 1 at edge N: first pcnt increment at edge N+1. With PRESCALE=P, the first tick is at edge N+1+P, then every P+1 cycles.
- MATCH, and irq if enabled, rise on the edge of the matching tick.
- gpio_in→GPIO_IN readback latency: 2 edges.
- No handshake. The CPU guarantees addr, cs, wr_rd and data_bus_write are stable for the whole cycle.

## Structure

- Package bus_timer_io_pkg:
  - register offset constants (3-bit)
  - CTRL bit positions
  - STATUS MATCH bit position
  - reset constant for COMPARE
- Sub-module Synchronizer: parameterized width, two-flop, async active-low reset, used for gpio_in.
- Everything else is flat in one module: register file, prescaler, counter, read mux.

## Test plan

- Reset: hold rst=0 with cs=1, wr_rd=0, addr=0x1C → data_bus_read=0. Release → read ID returns 32'h4D495053 and COMPARE reads 32'hFFFFFFFF.
- Count and match:
  - Setup: PRESCALE=2, COMPARE=3, CTRL=0x5.
  - COUNT increments every 3 cycles.
  - MATCH=1 and irq=1 on the tick where COUNT==3; COUNT reads 4 next.
  - Write STATUS=1 → irq=0 the next cycle.
- Auto-reload: with PRESCALE=0, COMPARE=1, CTRL=0x3 → COUNT sequence 0,1,0,1…, and MATCH is set.
- Collisions:
  - Write COUNT=0x100 on an edge with a tick → COUNT reads 0x100, not 0x101.
  - W1C of STATUS on a matching tick → MATCH stays 1.
- Wrap: COUNT=32'hFFFFFFFF, COMPARE=0x10, PRESCALE=0, EN=1 → COUNT reads 0 then 1, and MATCH stays 0.
- GPIO:
  - Write GPIO_OUT=0x1A5 → gpio_out=8'hA5 next cycle.
  - Drive gpio_in=8'h3C → GPIO_IN reads 0x3C after 2 edges.
  - cs=0 read → 0.
